// File: rtl/ram_bist_sequencer_if.sv
// RAM port bundle between the BIST sequencer (master) and the 64x32 word RAM (slave).
interface ram_bist_sequencer_if;
    logic [5:0]  Mem_Addr;
    logic        Mem_Write;
    logic [31:0] M_W_Data;
    logic [31:0] M_R_Data;

    modport master (output Mem_Addr, output Mem_Write, output M_W_Data, input M_R_Data);
    modport slave  (input Mem_Addr, input Mem_Write, input M_W_Data, output M_R_Data);
endinterface

// File: rtl/ram_bist_sequencer.sv
// BIST sequencer for the 64x32 RAM: writes a per-byte address pattern over a fixed window,
// reads every word back and reports pass/fail, the mismatch count and the first failing address.
module ram_bist_sequencer #(
    parameter logic [5:0] ADDR_LO  = 6'd0,
    parameter logic [5:0] ADDR_HI  = 6'd63,
    parameter logic [7:0] XOR_KEY  = 8'h00,
    parameter int         READ_LAT = 1
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Start,
    ram_bist_sequencer_if.master mem,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Pass,
    output logic [6:0]           Err_Count,
    output logic [5:0]           First_Err_Addr
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_WAIT,
        RD_CHK,
        DONE
    } state_t;

    // A zero-latency RAM answers in the same cycle, so the wait state is skipped entirely.
    localparam state_t     READ_ENTRY = (READ_LAT == 0) ? RD_CHK : RD_WAIT;
    localparam logic [1:0] WAIT_LAST  = (READ_LAT > 0) ? 2'(READ_LAT - 1) : 2'd0;

    state_t      state;
    logic [5:0]  addr_cnt;
    logic [1:0]  wait_cnt;
    logic        mem_write_q;
    logic [31:0] w_data_q;
    logic        rd_mismatch;

    function automatic logic [31:0] pattern(input logic [5:0] a);
        logic [31:0] p;
        p = '0;
        for (int k = 0; k < 4; k++) begin
            p[8*k +: 8] = {2'(k), a} ^ XOR_KEY;
        end
        return p;
    endfunction

    assign rd_mismatch   = (mem.M_R_Data != pattern(addr_cnt));
    assign mem.Mem_Addr  = addr_cnt;
    assign mem.Mem_Write = mem_write_q;
    assign mem.M_W_Data  = w_data_q;

    // NOTE: all state is updated with non-blocking assignments so every branch below
    // sees the pre-edge values of addr_cnt and Err_Count, whatever the statement order.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state          <= IDLE;
            addr_cnt       <= '0;
            wait_cnt       <= '0;
            mem_write_q    <= 1'b0;
            w_data_q       <= '0;
            Busy           <= 1'b0;
            Done           <= 1'b0;
            Pass           <= 1'b0;
            Err_Count      <= '0;
            First_Err_Addr <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        state          <= WRITE;
                        addr_cnt       <= ADDR_LO;
                        mem_write_q    <= 1'b1;
                        w_data_q       <= pattern(ADDR_LO);
                        Busy           <= 1'b1;
                        Done           <= 1'b0;
                        Pass           <= 1'b0;
                        Err_Count      <= '0;
                        First_Err_Addr <= '0;
                    end
                end

                WRITE: begin
                    if (addr_cnt == ADDR_HI) begin
                        state       <= READ_ENTRY;
                        addr_cnt    <= ADDR_LO;
                        wait_cnt    <= '0;
                        mem_write_q <= 1'b0;
                        w_data_q    <= '0;
                    end else begin
                        addr_cnt <= addr_cnt + 6'd1;
                        w_data_q <= pattern(addr_cnt + 6'd1);
                    end
                end

                RD_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state <= RD_CHK;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end

                RD_CHK: begin
                    if (rd_mismatch) begin
                        Err_Count <= Err_Count + 7'd1;
                        if (Err_Count == '0) begin
                            First_Err_Addr <= addr_cnt;
                        end
                    end
                    if (addr_cnt == ADDR_HI) begin
                        state <= DONE;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        Pass  <= (Err_Count == '0) && !rd_mismatch;
                    end else begin
                        state    <= READ_ENTRY;
                        addr_cnt <= addr_cnt + 6'd1;
                        wait_cnt <= '0;
                    end
                end

                default: begin
                    state       <= IDLE;
                    mem_write_q <= 1'b0;
                    w_data_q    <= '0;
                    Busy        <= 1'b0;
                    Done        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bist_sequencer.sv
// Bench for ram_bist_sequencer: four configurations against behavioural RAM models with
// selectable latency and stuck-at-0 read bits, checked against a pattern/timing model.
module tb_ram_bist_sequencer;

    localparam int LO[4]  = '{0, 63, 0, 0};
    localparam int HI[4]  = '{63, 63, 63, 63};
    localparam int KEY[4] = '{0, 255, 0, 0};
    localparam int LAT[4] = '{1, 1, 0, 3};

    logic        clk;
    logic        rst_n;
    logic        start[4];
    logic        busy[4];
    logic        done[4];
    logic        pass[4];
    logic [6:0]  err[4];
    logic [5:0]  first[4];
    logic [5:0]  addr[4];
    logic        we[4];
    logic [31:0] wdata[4];
    logic [31:0] rdata[4];
    logic [31:0] stuck_mask[4];
    logic [31:0] ram[4][64];
    logic [31:0] pipe[4][3];
    int          wr_cnt[4]  = '{default: 0};
    int          wd_viol[4] = '{default: 0};

    int n_tests = 0;
    int n_fail  = 0;

    ram_bist_sequencer_if bus0 ();
    ram_bist_sequencer_if bus1 ();
    ram_bist_sequencer_if bus2 ();
    ram_bist_sequencer_if bus3 ();

    ram_bist_sequencer dut0 (.Clk(clk), .Rst_n(rst_n), .Start(start[0]), .mem(bus0),
        .Busy(busy[0]), .Done(done[0]), .Pass(pass[0]), .Err_Count(err[0]), .First_Err_Addr(first[0]));
    ram_bist_sequencer #(.ADDR_LO(6'h3F), .ADDR_HI(6'h3F), .XOR_KEY(8'hFF), .READ_LAT(1)) dut1 (
        .Clk(clk), .Rst_n(rst_n), .Start(start[1]), .mem(bus1),
        .Busy(busy[1]), .Done(done[1]), .Pass(pass[1]), .Err_Count(err[1]), .First_Err_Addr(first[1]));
    ram_bist_sequencer #(.READ_LAT(0)) dut2 (.Clk(clk), .Rst_n(rst_n), .Start(start[2]), .mem(bus2),
        .Busy(busy[2]), .Done(done[2]), .Pass(pass[2]), .Err_Count(err[2]), .First_Err_Addr(first[2]));
    ram_bist_sequencer #(.READ_LAT(3)) dut3 (.Clk(clk), .Rst_n(rst_n), .Start(start[3]), .mem(bus3),
        .Busy(busy[3]), .Done(done[3]), .Pass(pass[3]), .Err_Count(err[3]), .First_Err_Addr(first[3]));

    assign addr[0] = bus0.Mem_Addr;  assign we[0] = bus0.Mem_Write;  assign wdata[0] = bus0.M_W_Data;
    assign addr[1] = bus1.Mem_Addr;  assign we[1] = bus1.Mem_Write;  assign wdata[1] = bus1.M_W_Data;
    assign addr[2] = bus2.Mem_Addr;  assign we[2] = bus2.Mem_Write;  assign wdata[2] = bus2.M_W_Data;
    assign addr[3] = bus3.Mem_Addr;  assign we[3] = bus3.Mem_Write;  assign wdata[3] = bus3.M_W_Data;
    assign bus0.M_R_Data = rdata[0];
    assign bus1.M_R_Data = rdata[1];
    assign bus2.M_R_Data = rdata[2];
    assign bus3.M_R_Data = rdata[3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: synchronous write, read data delayed LAT cycles, stuck-at-0 on masked read bits.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                ram[i][addr[i]] <= wdata[i];
                wr_cnt[i]       <= wr_cnt[i] + 1;
            end
            pipe[i][0] <= ram[i][addr[i]];
            pipe[i][1] <= pipe[i][0];
            pipe[i][2] <= pipe[i][1];
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rdata[i] = (LAT[i] == 0) ? ram[i][addr[i]] : pipe[i][(LAT[i] == 0) ? 0 : LAT[i] - 1];
            rdata[i] = rdata[i] & ~stuck_mask[i];
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!we[i] && wdata[i] != 32'h0) wd_viol[i] <= wd_viol[i] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int a, input int key);
        logic [31:0] w = '0;
        for (int k = 0; k < 4; k++) begin
            w = w | ((32'(((k * 64) + a) ^ key) & 32'hFF) << (8 * k));
        end
        return w;
    endfunction

    // Pulses Start for one cycle; cyc counts edges from the sampling edge (1) to the Done edge.
    task automatic run(input int i, output int cyc);
        int budget = (HI[i] - LO[i] + 1) * (LAT[i] + 2) + 20;
        @(negedge clk);
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
        cyc = 1;
        check($sformatf("busy_rise%0d", i), 32'(busy[i]), 1);
        while (!done[i] && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_run(input int i, input logic [31:0] mask, input int cyc);
        int n = HI[i] - LO[i] + 1;
        int exp_err = 0;
        int exp_first = 0;
        for (int a = LO[i]; a <= HI[i]; a++) begin
            if ((exp_word(a, KEY[i]) & mask) != 0) begin
                if (exp_err == 0) exp_first = a;
                exp_err++;
            end
        end
        check($sformatf("cycles%0d", i), cyc, n * (LAT[i] + 2) + 1);
        check($sformatf("done%0d", i), 32'(done[i]), 1);
        check($sformatf("busy_fall%0d", i), 32'(busy[i]), 0);
        check($sformatf("err_count%0d", i), 32'(err[i]), exp_err);
        check($sformatf("first_err%0d", i), 32'(first[i]), exp_first);
        check($sformatf("pass%0d", i), 32'(pass[i]), (exp_err == 0) ? 1 : 0);
    endtask

    task automatic check_outputs_reset(input string tag);
        check({tag, "_addr"}, 32'(addr[0]), 0);
        check({tag, "_we"}, 32'(we[0]), 0);
        check({tag, "_wdata"}, wdata[0], 0);
        check({tag, "_busy"}, 32'(busy[0]), 0);
        check({tag, "_done"}, 32'(done[0]), 0);
        check({tag, "_pass"}, 32'(pass[0]), 0);
        check({tag, "_err"}, 32'(err[0]), 0);
        check({tag, "_first"}, 32'(first[0]), 0);
    endtask

    initial begin
        int cyc;
        int w0;
        logic [31:0] saved[64];
        logic [31:0] tmp;

        start      = '{default: 1'b0};
        stuck_mask = '{default: 32'h0};
        rst_n      = 1'b0;
        #1;
        check_outputs_reset("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Fault-free default run.
        w0 = wr_cnt[0];
        run(0, cyc);
        check_run(0, 32'h0, cyc);
        check("writes0", wr_cnt[0] - w0, 64);
        check("word05", ram[0][5], 32'hC5854505);

        // Reset while writing must drop Mem_Write without a clock edge.
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (10) @(negedge clk);
        check("we_mid_write", 32'(we[0]), 1);
        #2 rst_n = 1'b0;
        #1 check_outputs_reset("rst_write");
        @(negedge clk);
        rst_n = 1'b1;

        // Stuck bit 3, random Start toggles in WRITE, Start held high from late in the read phase.
        stuck_mask[0] = 32'h8;
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (!done[0] && cyc < 250) begin
            start[0] = (cyc < 60) ? 1'($urandom_range(0, 1)) : (cyc >= 150);
            @(negedge clk);
            cyc++;
        end
        check_run(0, 32'h8, cyc);
        check("first_err_bit3", 32'(first[0]), 32'h08);

        // Start still high: DONE re-enters WRITE on the next edge with cleared results.
        stuck_mask[0] = 32'h0;
        @(negedge clk);
        start[0] = 1'b0;
        cyc = 1;
        check("rerun_busy", 32'(busy[0]), 1);
        check("rerun_done", 32'(done[0]), 0);
        check("rerun_err_clr", 32'(err[0]), 0);
        check("rerun_first_clr", 32'(first[0]), 0);
        while (cyc < 98) begin
            @(negedge clk);
            cyc++;
        end
        check("rdchk_addr", 32'(addr[0]), 32'h10);
        check("rdchk_we", 32'(we[0]), 0);
        check("rdchk_busy", 32'(busy[0]), 1);
        #2 rst_n = 1'b0;
        #1 check_outputs_reset("rst_rdchk");
        @(negedge clk);
        rst_n = 1'b1;
        run(0, cyc);
        check_run(0, 32'h0, cyc);

        // Random single stuck bits.
        repeat (3) begin
            stuck_mask[0] = 32'h1 << $urandom_range(0, 31);
            run(0, cyc);
            check_run(0, stuck_mask[0], cyc);
        end
        stuck_mask[0] = 32'h0;

        // Single-word window at 6'h3F with XOR_KEY = 8'hFF over randomly preset RAM.
        @(negedge clk);
        for (int a = 0; a < 64; a++) begin
            tmp = $urandom;
            saved[a] = tmp;
            ram[1][a] <= tmp;
        end
        w0 = wr_cnt[1];
        run(1, cyc);
        check_run(1, 32'h0, cyc);
        check("writes1", wr_cnt[1] - w0, 1);
        check("word3f", ram[1][63], 32'h004080C0);
        for (int a = 0; a < 63; a++) check($sformatf("untouched%0d", a), ram[1][a], saved[a]);

        // Zero and maximum read latency.
        for (int i = 2; i < 4; i++) begin
            run(i, cyc);
            check_run(i, 32'h0, cyc);
            for (int a = 0; a < 64; a++) check($sformatf("ram%0d_%0d", i, a), ram[i][a], exp_word(a, KEY[i]));
        end

        for (int i = 0; i < 4; i++) check($sformatf("wdata_idle_zero%0d", i), wd_viol[i], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
